// File: rtl/seq_divmod.sv
// Iterative unsigned divider/modulo: restoring division, one quotient bit per clock.
// Start/done responder; results hold until the next accepted request.
module seq_divmod #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  // S_ZERO spends the single cycle between a zero-divisor accept and DONE
  // without raising busy.
  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ZERO,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] sq_q, sq_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   trial;

  assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign trial     = {p_q, sq_q[WIDTH-1]} - {1'b0, b_q};

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = (b == '0) ? S_ZERO : S_CALC;
        end
      end
      S_CALC: begin
        if (last_iter) begin
          state_d = S_DONE;
        end
      end
      S_ZERO:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_CALC);
    done = (state_q == S_DONE);
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      p_q   <= '0;
      sq_q  <= '0;
      b_q   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      p_q   <= p_d;
      sq_q  <= sq_d;
      b_q   <= b_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end

  always_comb begin
    p_d   = p_q;
    sq_d  = sq_q;
    b_d   = b_q;
    quo_d = quo_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    if (accept) begin
      // The dividend sits in the shift register; the zero path reads it back as the remainder.
      p_d   = '0;
      sq_d  = a;
      b_d   = b;
      cnt_d = '0;
      dbz_d = 1'b0;
    end else if (state_q == S_CALC) begin
      if (!trial[WIDTH]) begin
        p_d  = trial[WIDTH-1:0];
        sq_d = {sq_q[WIDTH-2:0], 1'b1};
      end else begin
        p_d  = {p_q[WIDTH-2:0], sq_q[WIDTH-1]};
        sq_d = {sq_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (last_iter) begin
        quo_d = sq_d;
        rem_d = p_d;
      end
    end else if (state_q == S_ZERO) begin
      quo_d = '1;
      rem_d = sq_q;
      dbz_d = 1'b1;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divmod.sv
// Directed bench for seq_divmod: one task per scenario, inline checks against hand-computed values.
module tb_seq_divmod;

  logic        CLK;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int pass_cnt;
  int total_cnt;

  seq_divmod #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse start for one edge; returns 1ns after the accepting edge.
  task automatic send(input logic [31:0] av, input logic [31:0] bv);
    @(negedge CLK);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  // Edges counted from the accept edge until done is seen; -1 on timeout.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles      = -1;
    busy_cycles = 0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge CLK);
      #1;
      if (busy) busy_cycles++;
      if (done) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if ({busy, done, div_by_zero} !== 3'b000) $display("FAIL reset_flags: got %b exp 000", {busy, done, div_by_zero});
    else pass_cnt++;
    total_cnt++;
    if (quotient !== 32'd0 || remainder !== 32'd0) $display("FAIL reset_results: got q=%0h r=%0h exp 0 0", quotient, remainder);
    else pass_cnt++;
    @(negedge CLK);
    reset = 1'b0;
    @(posedge CLK);
    #1;
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL idle_after_reset: got %b exp 00", {busy, done});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int cyc, bcyc;
    send(32'd42, 32'd9);
    total_cnt++;
    if ({busy, done} !== 2'b10) $display("FAIL busy_after_accept: got %b exp 10", {busy, done});
    else pass_cnt++;
    wait_done(cyc, bcyc);
    total_cnt++;
    if (cyc !== 32) $display("FAIL latency_42_9: got %0d exp 32", cyc);
    else pass_cnt++;
    total_cnt++;
    if (bcyc !== 31 || busy !== 1'b0) $display("FAIL busy_span_42_9: got %0d busy=%b exp 31 busy=0", bcyc, busy);
    else pass_cnt++;
    total_cnt++;
    if (quotient !== 32'd4 || remainder !== 32'd6 || div_by_zero !== 1'b0)
      $display("FAIL result_42_9: got q=%0d r=%0d z=%b exp 4 6 0", quotient, remainder, div_by_zero);
    else pass_cnt++;
    repeat (3) @(posedge CLK);
    #1;
    total_cnt++;
    if (done !== 1'b1 || quotient !== 32'd4) $display("FAIL done_level: got done=%b q=%0d exp 1 4", done, quotient);
    else pass_cnt++;
  endtask

  task automatic test_boundaries();
    int cyc, bcyc;
    send(32'd5, 32'd7);
    wait_done(cyc, bcyc);
    total_cnt++;
    if (cyc !== 32 || quotient !== 32'd0 || remainder !== 32'd5)
      $display("FAIL div_5_7: got cyc=%0d q=%0h r=%0h exp 32 0 5", cyc, quotient, remainder);
    else pass_cnt++;
    send(32'hFFFF_FFFF, 32'd1);
    wait_done(cyc, bcyc);
    total_cnt++;
    if (cyc !== 32 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd0)
      $display("FAIL div_max_1: got cyc=%0d q=%0h r=%0h exp 32 ffffffff 0", cyc, quotient, remainder);
    else pass_cnt++;
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, bcyc);
    total_cnt++;
    if (cyc !== 32 || quotient !== 32'd1 || remainder !== 32'd0)
      $display("FAIL div_max_max: got cyc=%0d q=%0h r=%0h exp 32 1 0", cyc, quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_div_by_zero();
    int cyc, bcyc;
    send(32'd123, 32'd0);
    total_cnt++;
    if ({busy, done} !== 2'b00) $display("FAIL dbz_accept_flags: got %b exp 00", {busy, done});
    else pass_cnt++;
    wait_done(cyc, bcyc);
    total_cnt++;
    if (cyc !== 1 || bcyc !== 0) $display("FAIL dbz_latency: got cyc=%0d busy=%0d exp 1 0", cyc, bcyc);
    else pass_cnt++;
    total_cnt++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd123 || div_by_zero !== 1'b1)
      $display("FAIL dbz_result: got q=%0h r=%0d z=%b exp ffffffff 123 1", quotient, remainder, div_by_zero);
    else pass_cnt++;
    send(32'd10, 32'd3);
    total_cnt++;
    if (div_by_zero !== 1'b0 || done !== 1'b0 || quotient !== 32'hFFFF_FFFF)
      $display("FAIL dbz_clear_on_accept: got z=%b done=%b q=%0h exp 0 0 ffffffff", div_by_zero, done, quotient);
    else pass_cnt++;
    wait_done(cyc, bcyc);
    total_cnt++;
    if (cyc !== 32 || quotient !== 32'd3 || remainder !== 32'd1 || div_by_zero !== 1'b0)
      $display("FAIL div_10_3: got cyc=%0d q=%0d r=%0d z=%b exp 32 3 1 0", cyc, quotient, remainder, div_by_zero);
    else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int  done_n;
    bit  held_ok;
    done_n  = -1;
    held_ok = 1'b1;
    send(32'd100, 32'd7);
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (n == 10) begin
        a     = 32'd1;
        b     = 32'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge CLK);
      #1;
      if (done) begin
        done_n = n;
        break;
      end
      if (quotient !== 32'd3 || remainder !== 32'd1 || busy !== 1'b1) held_ok = 1'b0;
    end
    start = 1'b0;
    total_cnt++;
    if (held_ok !== 1'b1) $display("FAIL hold_during_calc: got %b exp 1", held_ok);
    else pass_cnt++;
    total_cnt++;
    if (done_n !== 32) $display("FAIL ignore_latency: got %0d exp 32", done_n);
    else pass_cnt++;
    total_cnt++;
    if (quotient !== 32'd14 || remainder !== 32'd2)
      $display("FAIL div_100_7: got q=%0d r=%0d exp 14 2", quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int cyc, bcyc;
    send(32'd1000, 32'd3);
    repeat (14) @(posedge CLK);
    #3;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0)
      $display("FAIL async_reset: got flags=%b q=%0d r=%0d exp 000 0 0", {busy, done, div_by_zero}, quotient, remainder);
    else pass_cnt++;
    @(negedge CLK);
    reset = 1'b0;
    send(32'd1000, 32'd3);
    wait_done(cyc, bcyc);
    total_cnt++;
    if (cyc !== 32 || quotient !== 32'd333 || remainder !== 32'd1)
      $display("FAIL div_1000_3: got cyc=%0d q=%0d r=%0d exp 32 333 1", cyc, quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc, spacing;
    @(negedge CLK);
    a     = 32'd50;
    b     = 32'd5;
    start = 1'b1;
    @(posedge CLK);
    #1;
    a = 32'd51;
    wait_done(cyc, bcyc);
    total_cnt++;
    if (cyc !== 32 || quotient !== 32'd10 || remainder !== 32'd0)
      $display("FAIL b2b_first: got cyc=%0d q=%0d r=%0d exp 32 10 0", cyc, quotient, remainder);
    else pass_cnt++;
    @(posedge CLK);
    #1;
    total_cnt++;
    if ({busy, done} !== 2'b10) $display("FAIL b2b_done_one_cycle: got %b exp 10", {busy, done});
    else pass_cnt++;
    wait_done(cyc, bcyc);
    spacing = (cyc < 0) ? -1 : cyc + 1;
    start = 1'b0;
    total_cnt++;
    if (spacing !== 33) $display("FAIL b2b_spacing: got %0d exp 33", spacing);
    else pass_cnt++;
    total_cnt++;
    if (quotient !== 32'd10 || remainder !== 32'd1)
      $display("FAIL b2b_second: got q=%0d r=%0d exp 10 1", quotient, remainder);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    test_reset();
    test_basic();
    test_boundaries();
    test_div_by_zero();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
